// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: writeback-source selects,
// load funct3 codes and FSM state encodings.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;

endpackage

// File: rtl/wb_load_align.sv
// Combinational sub-word load alignment: picks the byte/half/word field
// selected by the address offset and sign- or zero-extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int OFF_W     = $clog2(WORD_SIZE / 8)
) (
    input  logic [2:0]           loadType,
    input  logic [OFF_W-1:0]     offset,
    input  logic [WORD_SIZE-1:0] rawWord,
    output logic [WORD_SIZE-1:0] extWord
);

    logic [OFF_W-1:0] offHalf;
    logic [OFF_W-1:0] offWord;
    logic [7:0]       fieldB;
    logic [15:0]      fieldH;
    logic [31:0]      fieldW;

    // Misaligned accesses are not trapped: drop the low index bits instead.
    assign offHalf = offset & ~OFF_W'(1);
    assign offWord = offset & ~OFF_W'(3);

    assign fieldB = 8'(rawWord >> {offset, 3'b000});
    assign fieldH = 16'(rawWord >> {offHalf, 3'b000});
    assign fieldW = 32'(rawWord >> {offWord, 3'b000});

    always_comb begin
        extWord = rawWord;
        case (loadType)
            LD_B:    extWord = WORD_SIZE'($signed(fieldB));
            LD_H:    extWord = WORD_SIZE'($signed(fieldH));
            LD_W:    extWord = WORD_SIZE'($signed(fieldW));
            LD_BU:   extWord = WORD_SIZE'(fieldB);
            LD_HU:   extWord = WORD_SIZE'(fieldH);
            LD_WU:   extWord = WORD_SIZE'(fieldW);
            LD_D:    extWord = rawWord;
            default: extWord = rawWord;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB register, load-data wait, align/extend and
// source select. Optional retire counter enabled by WB_RETIRE_CNT_EN.
//
// state       | meaning
// ST_EMPTY    | no instruction held
// ST_WAIT_MEM | load accepted, waiting for mem_rvalid
// ST_WRITE    | rf_* / fwd_* present a completed instruction
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 in_reg_write,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_load_type,
    input  logic [REG_SIZE-1:0]  in_dest_reg,
    input  logic [WORD_SIZE-1:0] in_alu_result,
    input  logic [WORD_SIZE-1:0] in_pc_plus4,
    input  logic                 mem_rvalid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 rf_we,
    output logic [REG_SIZE-1:0]  rf_waddr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    output logic                 fwd_valid,
    output logic [REG_SIZE-1:0]  fwd_reg,
    output logic [WORD_SIZE-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]          retire_count
`endif
);

    localparam int OFF_W = $clog2(WORD_SIZE / 8);

    logic [1:0]           state;
    logic [2:0]           pendType;
    logic [OFF_W-1:0]     pendOffset;
    logic                 pendWrite;
    logic                 accept;
    logic [WORD_SIZE-1:0] loadWord;
    logic [WORD_SIZE-1:0] directData;

    assign in_ready = !flush && (state == ST_EMPTY || state == ST_WRITE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        directData = in_alu_result;
        case (in_wb_sel)
            WB_SEL_ALU: directData = in_alu_result;
            WB_SEL_PC4: directData = in_pc_plus4;
            default:    directData = in_alu_result;
        endcase
    end

    wb_load_align #(
        .WORD_SIZE (WORD_SIZE),
        .OFF_W     (OFF_W)
    ) u_align (
        .loadType (pendType),
        .offset   (pendOffset),
        .rawWord  (mem_rdata),
        .extWord  (loadWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pendType   <= '0;
            pendOffset <= '0;
            pendWrite  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_MEM: begin
                    // Flush beats a same-cycle mem_rvalid: the load is simply dropped.
                    if (flush) begin
                        state <= ST_EMPTY;
                        rf_we <= 1'b0;
                    end else if (mem_rvalid) begin
                        state    <= ST_WRITE;
                        rf_we    <= pendWrite && (rf_waddr != '0);
                        rf_wdata <= loadWord;
                    end
                end
                default: begin
                    if (accept) begin
                        rf_waddr   <= in_dest_reg;
                        pendWrite  <= in_reg_write;
                        pendType   <= in_load_type;
                        pendOffset <= in_alu_result[OFF_W-1:0];
                        if (in_wb_sel == WB_SEL_MEM) begin
                            state <= ST_WAIT_MEM;
                            rf_we <= 1'b0;
                        end else begin
                            state    <= ST_WRITE;
                            rf_we    <= in_reg_write && (in_dest_reg != '0);
                            rf_wdata <= directData;
                        end
                    end else begin
                        state <= ST_EMPTY;
                        rf_we <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_reg   = rf_waddr;
    assign fwd_data  = rf_wdata;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (state == ST_WRITE) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, flush, in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_load_type;
    logic [4:0]  in_dest_reg;
    logic [31:0] in_alu_result, in_pc_plus4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we, fwd_valid;
    logic [4:0]  rf_waddr, fwd_reg;
    logic [31:0] rf_wdata, fwd_data;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int total = 0;
    int bad   = 0;

    wb_stage_pipe #(.WORD_SIZE(32), .REG_SIZE(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .in_reg_write  (in_reg_write),
        .in_wb_sel     (in_wb_sel),
        .in_load_type  (in_load_type),
        .in_dest_reg   (in_dest_reg),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load extraction built from a byte view of the memory word.
    function automatic logic [31:0] refAlign(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [7:0] by [4];
        int o;
        int hi;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        o  = int'(a[1:0]);
        hi = o - (o % 2);
        case (t)
            3'b000:  return {{24{by[o][7]}}, by[o]};
            3'b100:  return {24'h0, by[o]};
            3'b001:  return {{16{by[hi+1][7]}}, by[hi+1], by[hi]};
            3'b101:  return {16'h0, by[hi+1], by[hi]};
            default: return w;
        endcase
    endfunction

    // Transaction model: one outstanding load at most, one visible write per cycle.
    bit          mPend, mInWrite, mWe, mWr;
    logic [2:0]  mType;
    logic [31:0] mAddr, mWdata;
    logic [4:0]  mDest, mWaddr;
    int unsigned mCount;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPend = 0; mInWrite = 0; mWe = 0; mCount = 0;
        end else begin
            if (mInWrite) mCount++;
            mInWrite = 0;
            mWe      = 0;
            if (mPend) begin
                if (flush) begin
                    mPend = 0;
                end else if (mem_rvalid) begin
                    mPend    = 0;
                    mInWrite = 1;
                    mWaddr   = mDest;
                    mWdata   = refAlign(mType, mAddr, mem_rdata);
                    mWe      = mWr && (mDest != 0);
                end
            end else if (in_valid && !flush) begin
                if (in_wb_sel == 2'b01) begin
                    mPend = 1;
                    mType = in_load_type;
                    mAddr = in_alu_result;
                    mDest = in_dest_reg;
                    mWr   = in_reg_write;
                end else begin
                    mInWrite = 1;
                    mWaddr   = in_dest_reg;
                    mWdata   = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                    mWe      = in_reg_write && (in_dest_reg != 0);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (mInWrite) begin
            check("rf_we", rf_we, mWe);
            check("rf_waddr", rf_waddr, mWaddr);
            check("rf_wdata", rf_wdata, mWdata);
            check("fwd_valid", fwd_valid, mWe);
            check("fwd_reg", fwd_reg, mWaddr);
            check("fwd_data", fwd_data, mWdata);
        end else begin
            check("rf_we idle", rf_we, 0);
            check("fwd_valid idle", fwd_valid, 0);
        end
        check("in_ready", in_ready, !flush && !mPend);
`ifdef WB_RETIRE_CNT_EN
        check("retire_count", retire_count, mCount);
`endif
    end

    task automatic drive(input bit v, input logic [1:0] sel, input logic [2:0] lt,
                         input logic [4:0] d, input logic [31:0] alu, input logic [31:0] pc,
                         input bit rw, input bit fl, input bit rv, input logic [31:0] rd);
        @(negedge clk);
        in_valid = v; in_wb_sel = sel; in_load_type = lt; in_dest_reg = d;
        in_alu_result = alu; in_pc_plus4 = pc; in_reg_write = rw; flush = fl;
        mem_rvalid = rv; mem_rdata = rd;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; flush = 0; in_reg_write = 0; in_wb_sel = 0; in_load_type = 0;
        in_dest_reg = 0; in_alu_result = 0; in_pc_plus4 = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rf_we", rf_we, 0);
        check("reset rf_waddr", rf_waddr, 0);
        check("reset rf_wdata", rf_wdata, 0);
        check("reset fwd_valid", fwd_valid, 0);
        check("reset in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;

        drive(1, 2'b00, 3'b000, 5'd2, 32'h14, 32'h0, 1, 0, 0, 32'h0); settle();
        check("alu we", rf_we, 1);
        check("alu waddr", rf_waddr, 2);
        check("alu wdata", rf_wdata, 32'h14);
        check("alu fwd_valid", fwd_valid, 1);
        check("alu fwd_reg", fwd_reg, 2);
        check("alu fwd_data", fwd_data, 32'h14);

        drive(1, 2'b01, 3'b000, 5'd5, 32'h1001, 32'h0, 1, 0, 0, 32'h0); settle();
        check("lb wait ready 1", in_ready, 0);
        drive(1, 2'b00, 3'b000, 5'd7, 32'h55, 32'h0, 1, 0, 0, 32'h0); settle();
        check("lb wait ready 2", in_ready, 0);
        check("lb wait we", rf_we, 0);
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0); settle();
        check("lb wait ready 3", in_ready, 0);
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 1, 32'h0000_8F00); settle();
        check("lb we", rf_we, 1);
        check("lb waddr", rf_waddr, 5);
        check("lb wdata", rf_wdata, 32'hFFFF_FF8F);

        drive(1, 2'b01, 3'b101, 5'd6, 32'h2002, 32'h0, 1, 0, 0, 32'h0); settle();
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 1, 32'hBEEF_0000); settle();
        check("lhu wdata", rf_wdata, 32'h0000_BEEF);

        drive(1, 2'b01, 3'b010, 5'd7, 32'h3000, 32'h0, 1, 0, 0, 32'h0); settle();
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 1, 32'h16); settle();
        check("lw wdata", rf_wdata, 32'h16);

        drive(1, 2'b10, 3'b000, 5'd1, 32'h999, 32'h104, 1, 0, 0, 32'h0); settle();
        check("jal we", rf_we, 1);
        check("jal wdata", rf_wdata, 32'h104);
        drive(1, 2'b10, 3'b000, 5'd0, 32'h999, 32'h104, 1, 0, 0, 32'h0); settle();
        check("jal x0 we", rf_we, 0);
        check("jal x0 fwd_valid", fwd_valid, 0);

        drive(1, 2'b01, 3'b000, 5'd9, 32'h40, 32'h0, 1, 0, 0, 32'h0); settle();
        drive(1, 2'b00, 3'b000, 5'd3, 32'h1, 32'h0, 1, 1, 1, 32'hAA); #1;
        check("flush cycle ready", in_ready, 0);
        settle();
        check("flush no write", rf_we, 0);
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0); #1;
        check("after flush ready", in_ready, 1);
        settle();
        check("after flush we", rf_we, 0);

        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b00, 3'b000, 5'(10 + i), 32'h100 + i, 32'h0, 1, 0, 0, 32'h0); settle();
            check("b2b we", rf_we, 1);
            check("b2b wdata", rf_wdata, 32'h100 + i);
        end
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0); settle();
`ifdef WB_RETIRE_CNT_EN
        check("retire 4", retire_count, 4);
`endif
        drive(1, 2'b00, 3'b000, 5'd3, 32'h77, 32'h0, 1, 0, 0, 32'h0); settle();
        #2;
        rst_n = 0;
        #1;
        check("async rst rf_we", rf_we, 0);
        check("async rst rf_waddr", rf_waddr, 0);
        check("async rst rf_wdata", rf_wdata, 0);
        check("async rst fwd_valid", fwd_valid, 0);
        check("async rst fwd_data", fwd_data, 0);
`ifdef WB_RETIRE_CNT_EN
        check("async rst retire", retire_count, 0);
`endif
        @(negedge clk); rst_n = 1;

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 5'($urandom),
                  $urandom, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        drive(0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        rst_n = 1;
        settle();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
